// File: rtl/bigblade_clk_pkg.sv
// Shared types for the BigBlade clock downsampler: per-channel config record and
// apply-boundary encoding. Latency/backpressure: n/a (types only).
`ifndef BIGBLADE_CLK_DS_CFG_S
`define BIGBLADE_CLK_DS_CFG_S(w) struct packed { logic en; logic [(w)-1:0] ds; }
`endif

package bigblade_clk_pkg;

    typedef enum logic [1:0] {
        BND_NONE = 2'd0,
        BND_FALL = 2'd1,
        BND_IDLE = 2'd2,
        BND_SYNC = 2'd3
    } bigblade_clk_bnd_e;

    // Channel-select width always leaves room for at least one out-of-range code.
    function automatic int unsigned chan_sel_width(input int unsigned n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/bigblade_clk_ds_chan.sv
// One divided-clock channel with a one-deep shadow config applied only at safe boundaries.
// Latency: config lands 1 cycle after write, applies at next boundary; backpressure via o_pending.
module bigblade_clk_ds_chan
    import bigblade_clk_pkg::*;
#(
    parameter int ds_width_p = 6,
    parameter int reset_ds_p = 0,
    parameter int reset_en_p = 1
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_sync,
    input  logic                  i_cfg_we,
    input  logic [ds_width_p-1:0] i_cfg_ds,
    input  logic                  i_cfg_en,
    output logic                  o_clk,
    output logic                  o_pending
);

    typedef `BIGBLADE_CLK_DS_CFG_S(ds_width_p) bigblade_clk_ds_cfg_s;

    bigblade_clk_ds_cfg_s  r_shadow;
    logic [ds_width_p-1:0] r_cnt;
    logic [ds_width_p-1:0] r_ds;
    logic                  r_clk;
    logic                  r_en;
    logic                  r_pending;
    logic                  w_hit;
    logic                  w_apply;
    bigblade_clk_bnd_e     w_bnd;

    assign w_hit = (r_cnt == r_ds);

    // Only these points can take new settings without shortening a high phase
    // (sync is the deliberate exception).
    always_comb begin
        w_bnd = BND_NONE;
        if (i_sync) begin
            w_bnd = BND_SYNC;
        end else if (!r_en) begin
            w_bnd = BND_IDLE;
        end else if (r_clk && w_hit) begin
            w_bnd = BND_FALL;
        end
    end

    assign w_apply = r_pending && (w_bnd != BND_NONE);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cnt       <= '0;
            r_clk       <= 1'b0;
            r_ds        <= ds_width_p'(reset_ds_p);
            r_en        <= (reset_en_p != 0);
            r_pending   <= 1'b0;
            r_shadow.en <= 1'b0;
            r_shadow.ds <= '0;
        end else begin
            if (i_sync || !r_en) begin
                r_cnt <= '0;
                r_clk <= 1'b0;
            end else if (w_hit) begin
                r_cnt <= '0;
                r_clk <= ~r_clk;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end

            if (w_apply) begin
                r_ds      <= r_shadow.ds;
                r_en      <= r_shadow.en;
                r_pending <= 1'b0;
            end else if (i_cfg_we) begin
                r_shadow.ds <= i_cfg_ds;
                r_shadow.en <= i_cfg_en;
                r_pending   <= 1'b1;
            end
        end
    end

    assign o_clk     = r_clk;
    assign o_pending = r_pending;

endmodule

// File: rtl/bigblade_clk_ds_multi.sv
// Multi-channel root-clock downsampler with shared config port and global disable/realign.
// Latency: disable 1 cycle; backpressure: cfg_ready_o low while target channel has a pending config.
module bigblade_clk_ds_multi
    import bigblade_clk_pkg::*;
#(
    parameter int num_chan_p = 4,
    parameter int ds_width_p = 6,
    parameter int reset_ds_p = 0,
    parameter int reset_en_p = 1,
    localparam int chan_w_lp = chan_sel_width(num_chan_p)
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  cfg_v_i,
    output logic                  cfg_ready_o,
    input  logic [chan_w_lp-1:0]  cfg_chan_i,
    input  logic [ds_width_p-1:0] cfg_ds_i,
    input  logic                  cfg_en_i,
    input  logic                  sync_i,
    input  logic                  output_disable_i,
    output logic [num_chan_p-1:0] clk_o,
    output logic [num_chan_p-1:0] pending_o
);

    logic                  r_disable;
    logic [num_chan_p-1:0] w_clk;
    logic [num_chan_p-1:0] w_we;

    // Out-of-range channel codes stay ready so the request is swallowed.
    always_comb begin
        cfg_ready_o = 1'b1;
        w_we        = '0;
        for (int i = 0; i < num_chan_p; i++) begin
            if (cfg_chan_i == chan_w_lp'(i)) begin
                cfg_ready_o = ~pending_o[i];
                w_we[i]     = cfg_v_i & ~pending_o[i];
            end
        end
    end

    for (genvar g = 0; g < num_chan_p; g++) begin : g_chan
        bigblade_clk_ds_chan #(
            .ds_width_p (ds_width_p),
            .reset_ds_p (reset_ds_p),
            .reset_en_p (reset_en_p)
        ) u_chan (
            .i_clk     (clk_i),
            .i_reset   (reset_i),
            .i_sync    (sync_i),
            .i_cfg_we  (w_we[g]),
            .i_cfg_ds  (cfg_ds_i),
            .i_cfg_en  (cfg_en_i),
            .o_clk     (w_clk[g]),
            .o_pending (pending_o[g])
        );
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_disable <= 1'b0;
        end else begin
            r_disable <= output_disable_i;
        end
    end

    assign clk_o = w_clk & ~{num_chan_p{r_disable}};

endmodule

// File: tb/tb_bigblade_clk_ds_multi.sv
// Directed bench: stimulus queues hand-computed per-cycle expectations, a negedge monitor
// pops and compares clk_o/pending_o; cfg_ready_o is checked inline.
module tb_bigblade_clk_ds_multi;

    localparam int NC = 4;
    localparam int DW = 6;
    localparam int CW = $clog2(NC + 1);

    logic          clk_i = 1'b0;
    logic          reset_i;
    logic          cfg_v_i;
    logic          cfg_ready_o;
    logic [CW-1:0] cfg_chan_i;
    logic [DW-1:0] cfg_ds_i;
    logic          cfg_en_i;
    logic          sync_i;
    logic          output_disable_i;
    logic [NC-1:0] clk_o;
    logic [NC-1:0] pending_o;

    bigblade_clk_ds_multi #(
        .num_chan_p (NC),
        .ds_width_p (DW),
        .reset_ds_p (0),
        .reset_en_p (1)
    ) dut (
        .clk_i            (clk_i),
        .reset_i          (reset_i),
        .cfg_v_i          (cfg_v_i),
        .cfg_ready_o      (cfg_ready_o),
        .cfg_chan_i       (cfg_chan_i),
        .cfg_ds_i         (cfg_ds_i),
        .cfg_en_i         (cfg_en_i),
        .sync_i           (sync_i),
        .output_disable_i (output_disable_i),
        .clk_o            (clk_o),
        .pending_o        (pending_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int       cyc;
        logic [3:0] mask;
        logic [3:0] val;
        bit       pchk;
        logic [3:0] pval;
    } exp_t;

    exp_t sb_q[$];
    int   cyc  = 0;
    int   nchk = 0;
    int   nerr = 0;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic push(input int c, input logic [3:0] m, input logic [3:0] v,
                        input bit pc, input logic [3:0] pv);
        exp_t e;
        int   idx;
        e.cyc = c; e.mask = m; e.val = v; e.pchk = pc; e.pval = pv;
        idx = sb_q.size();
        while (idx > 0 && sb_q[idx-1].cyc > c) idx--;
        sb_q.insert(idx, e);
    endtask

    task automatic ex(input int c, input logic [3:0] m, input logic [3:0] v);
        push(c, m, v, 1'b0, 4'h0);
    endtask

    task automatic exp_p(input int c, input logic [3:0] m, input logic [3:0] v, input logic [3:0] pv);
        push(c, m, v, 1'b1, pv);
    endtask

    // Monitor: state after posedge k is compared at negedge k.
    always @(negedge clk_i) begin
        exp_t e;
        while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
            e = sb_q.pop_front();
            nchk++;
            if (e.cyc != cyc) begin
                nerr++;
                $display("FAIL sb_missed: expectation for cycle %0d seen at cycle %0d", e.cyc, cyc);
            end else if ((clk_o & e.mask) !== (e.val & e.mask)) begin
                nerr++;
                $display("FAIL clk_o cyc=%0d mask=%b: got %b want %b", cyc, e.mask, clk_o & e.mask, e.val & e.mask);
            end
            if (e.pchk) begin
                nchk++;
                if (pending_o !== e.pval) begin
                    nerr++;
                    $display("FAIL pending_o cyc=%0d: got %b want %b", cyc, pending_o, e.pval);
                end
            end
        end
    end

    task automatic wait_cyc(input int n);
        while (cyc != n) begin
            @(negedge clk_i);
            #1;
        end
    endtask

    task automatic drive_cfg(input int ch, input int ds, input bit en);
        cfg_v_i    = 1'b1;
        cfg_chan_i = CW'(ch);
        cfg_ds_i   = DW'(ds);
        cfg_en_i   = en;
    endtask

    task automatic chk_ready(input logic want);
        #1;
        nchk++;
        if (cfg_ready_o !== want) begin
            nerr++;
            $display("FAIL cfg_ready_o cyc=%0d chan=%0d: got %b want %b", cyc, cfg_chan_i, cfg_ready_o, want);
        end
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not complete, cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        reset_i = 1'b1; cfg_v_i = 1'b0; cfg_chan_i = '0; cfg_ds_i = '0;
        cfg_en_i = 1'b0; sync_i = 1'b0; output_disable_i = 1'b0;

        // Reset defaults: low at release, then period 2 on every channel.
        exp_p(3, 4'hf, 4'h0, 4'h0);
        ex(4, 4'hf, 4'hf);
        ex(5, 4'hf, 4'h0);
        exp_p(6, 4'hf, 4'hf, 4'h0);
        wait_cyc(3);
        reset_i = 1'b0;

        // Channel 1: N=0 -> N=3, applied at falling boundary on edge 9.
        wait_cyc(6);
        exp_p(7, 4'b0010, 4'b0000, 4'b0010);
        exp_p(8, 4'b0010, 4'b0010, 4'b0010);
        exp_p(9, 4'b0010, 4'b0000, 4'b0000);
        ex(12, 4'b0010, 4'b0000);
        ex(13, 4'b0010, 4'b0010);
        ex(16, 4'b0010, 4'b0010);
        ex(17, 4'b0010, 4'b0000);
        ex(20, 4'b0010, 4'b0000);
        ex(21, 4'b0010, 4'b0010);
        drive_cfg(1, 3, 1'b1);
        chk_ready(1'b1);
        wait_cyc(7);
        cfg_v_i = 1'b0;

        // Back-to-back config to channel 2: second waits for first to apply.
        wait_cyc(22);
        exp_p(23, 4'b0100, 4'b0000, 4'b0100);
        exp_p(24, 4'b0100, 4'b0100, 4'b0100);
        exp_p(25, 4'b0100, 4'b0000, 4'b0000);
        exp_p(26, 4'b0100, 4'b0000, 4'b0100);
        ex(27, 4'b0100, 4'b0100);
        exp_p(28, 4'b0100, 4'b0100, 4'b0100);
        exp_p(29, 4'b0100, 4'b0000, 4'b0000);
        ex(31, 4'b0100, 4'b0000);
        ex(32, 4'b0100, 4'b0100);
        ex(34, 4'b0100, 4'b0100);
        ex(35, 4'b0100, 4'b0000);
        ex(38, 4'b0100, 4'b0100);
        drive_cfg(2, 1, 1'b1);
        chk_ready(1'b1);
        wait_cyc(23);
        drive_cfg(2, 2, 1'b1);
        chk_ready(1'b0);
        wait_cyc(24);
        chk_ready(1'b0);
        wait_cyc(25);
        chk_ready(1'b1);
        wait_cyc(26);
        cfg_v_i = 1'b0;

        // Out-of-range channel: accepted, nothing changes.
        wait_cyc(38);
        exp_p(39, 4'h0, 4'h0, 4'h0);
        exp_p(40, 4'hf, 4'b1111, 4'h0);
        ex(41, 4'hf, 4'b0000);
        ex(44, 4'hf, 4'b1101);
        exp_p(45, 4'hf, 4'b0110, 4'h0);
        drive_cfg(7, 5, 1'b0);
        chk_ready(1'b1);
        wait_cyc(39);
        cfg_v_i = 1'b0;

        // Channel 0: N=5, disable mid-high, then re-enable from idle.
        wait_cyc(46);
        exp_p(47, 4'b0001, 4'b0000, 4'b0001);
        exp_p(49, 4'b0001, 4'b0000, 4'b0000);
        ex(54, 4'b0001, 4'b0000);
        ex(55, 4'b0001, 4'b0001);
        exp_p(58, 4'b0001, 4'b0001, 4'b0001);
        ex(60, 4'b0001, 4'b0001);
        exp_p(61, 4'b0001, 4'b0000, 4'b0000);
        exp_p(65, 4'b0001, 4'b0000, 4'b0001);
        exp_p(66, 4'b0001, 4'b0000, 4'b0000);
        ex(67, 4'b0001, 4'b0000);
        ex(71, 4'b0001, 4'b0000);
        ex(72, 4'b0001, 4'b0001);
        ex(77, 4'b0001, 4'b0001);
        ex(78, 4'b0001, 4'b0000);
        drive_cfg(0, 5, 1'b1);
        chk_ready(1'b1);
        wait_cyc(47);
        cfg_v_i = 1'b0;
        wait_cyc(57);
        drive_cfg(0, 5, 1'b0);
        chk_ready(1'b1);
        wait_cyc(58);
        cfg_v_i = 1'b0;
        wait_cyc(64);
        drive_cfg(0, 5, 1'b1);
        chk_ready(1'b1);
        wait_cyc(65);
        cfg_v_i = 1'b0;

        // Channel 3 to N=1, then sync: ch3/ch2/ch1/ch0 at N=1/2/3/5.
        wait_cyc(80);
        drive_cfg(3, 1, 1'b1);
        chk_ready(1'b1);
        wait_cyc(81);
        cfg_v_i = 1'b0;
        wait_cyc(90);
        exp_p(91, 4'hf, 4'b0000, 4'h0);
        ex(92, 4'hf, 4'b0000);
        ex(93, 4'hf, 4'b1000);
        ex(94, 4'hf, 4'b1100);
        ex(95, 4'hf, 4'b0110);
        ex(96, 4'hf, 4'b0110);
        ex(97, 4'hf, 4'b1011);
        ex(98, 4'hf, 4'b1011);
        ex(99, 4'hf, 4'b0001);
        ex(100, 4'hf, 4'b0101);
        ex(101, 4'hf, 4'b1101);
        // Output disable for windows 110..112 blanks cycles 111..113 only.
        ex(110, 4'hf, 4'b1001);
        ex(111, 4'hf, 4'b0000);
        ex(112, 4'hf, 4'b0000);
        ex(113, 4'hf, 4'b0000);
        ex(114, 4'hf, 4'b1111);
        ex(115, 4'hf, 4'b0000);
        ex(116, 4'hf, 4'b0000);
        ex(117, 4'hf, 4'b1000);
        sync_i = 1'b1;
        wait_cyc(91);
        sync_i = 1'b0;
        wait_cyc(110);
        output_disable_i = 1'b1;
        wait_cyc(113);
        output_disable_i = 1'b0;

        // Reset while channel 1 has a pending config.
        wait_cyc(120);
        exp_p(121, 4'h0, 4'h0, 4'b0010);
        exp_p(122, 4'hf, 4'b0000, 4'h0);
        ex(123, 4'hf, 4'b1111);
        ex(124, 4'hf, 4'b0000);
        exp_p(125, 4'hf, 4'b1111, 4'h0);
        drive_cfg(1, 7, 1'b1);
        chk_ready(1'b1);
        wait_cyc(121);
        cfg_v_i = 1'b0;
        reset_i = 1'b1;
        wait_cyc(122);
        reset_i = 1'b0;

        wait_cyc(130);
        nchk++;
        if (sb_q.size() != 0) begin
            nerr++;
            $display("FAIL sb_drain: got %0d leftover expectations want 0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
